// File: rtl/adi2axis_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : adi2axis_fifo_pkg
//  Purpose  : Shared types and helpers for the ADC-to-AXIS path and its FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
package adi2axis_fifo_pkg;

   localparam int DROP_CNT_W = 16;

   typedef enum logic [0:0] {
      ST_NORMAL = 1'b0,
      ST_DROP   = 1'b1
   } fifo_state_t;

   // Byte count to TDATA bit width; shared with the converter.
   function automatic int tdata_width(input int num_bytes);
      return 8 * num_bytes;
   endfunction

endpackage : adi2axis_fifo_pkg
`default_nettype wire

// File: rtl/adi2axis_fifo_ram.sv
`default_nettype none
// ============================================================================
//  Module   : adi2axis_fifo_ram
//  Purpose  : Simple dual-port array, synchronous write, asynchronous read.
//  Revision : 1.0 - initial release
// ============================================================================
module adi2axis_fifo_ram
   import adi2axis_fifo_pkg::*;
#(
   parameter int WIDTH  = 72,
   parameter int ADDR_W = 9
)(
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [WIDTH-1:0]  i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [WIDTH-1:0]  o_rdata
);

   localparam int C_DEPTH = 1 << ADDR_W;

   logic [WIDTH-1:0] r_mem [C_DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule : adi2axis_fifo_ram
`default_nettype wire

// File: rtl/adi2axis_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : adi2axis_fifo
//  Purpose  : Elastic AXIS buffer that drops whole-packet tails on overflow.
//  Revision : 1.0 - initial release
// ============================================================================
module adi2axis_fifo
   import adi2axis_fifo_pkg::*;
#(
   parameter int C_AXIS_TDATA_NUM_BYTES = 8,
   parameter int C_DEPTH_LOG2           = 9
)(
   input  logic                                  AXIS_ACLK,
   input  logic                                  AXIS_ARESET,
   input  logic                                  S_AXIS_TVALID,
   input  logic [8*C_AXIS_TDATA_NUM_BYTES-1:0]   S_AXIS_TDATA,
   input  logic [C_AXIS_TDATA_NUM_BYTES-1:0]     S_AXIS_TSTRB,
   input  logic                                  S_AXIS_TLAST,
   output logic                                  S_AXIS_TREADY,
   output logic                                  M_AXIS_TVALID,
   output logic [8*C_AXIS_TDATA_NUM_BYTES-1:0]   M_AXIS_TDATA,
   output logic [C_AXIS_TDATA_NUM_BYTES-1:0]     M_AXIS_TSTRB,
   output logic                                  M_AXIS_TLAST,
   input  logic                                  M_AXIS_TREADY,
   input  logic                                  clr,
   output logic [C_DEPTH_LOG2:0]                 level,
   output logic                                  ovf,
   output logic [DROP_CNT_W-1:0]                 drop_cnt
);

   localparam int C_DATA_W = tdata_width(C_AXIS_TDATA_NUM_BYTES);
   localparam int C_MEM_W  = C_DATA_W + C_AXIS_TDATA_NUM_BYTES;
   localparam int C_DEPTH  = 1 << C_DEPTH_LOG2;

   localparam logic [C_DEPTH_LOG2:0]   C_CNT_FULL = {1'b1, {C_DEPTH_LOG2{1'b0}}};
   localparam logic [C_DEPTH_LOG2:0]   C_CNT_ONE  = {{C_DEPTH_LOG2{1'b0}}, 1'b1};
   localparam logic [C_DEPTH_LOG2-1:0] C_PTR_ONE  = {{(C_DEPTH_LOG2-1){1'b0}}, 1'b1};
   localparam logic [DROP_CNT_W-1:0]   C_DROP_MAX = {DROP_CNT_W{1'b1}};
   localparam logic [DROP_CNT_W-1:0]   C_DROP_ONE = {{(DROP_CNT_W-1){1'b0}}, 1'b1};

   fifo_state_t               r_state;
   fifo_state_t               w_state_nxt;
   logic [C_DEPTH_LOG2-1:0]   r_wr_ptr;
   logic [C_DEPTH_LOG2-1:0]   r_rd_ptr;
   logic [C_DEPTH_LOG2-1:0]   w_last_ptr;
   logic [C_DEPTH_LOG2:0]     r_count;
   logic [C_DEPTH-1:0]        r_tlast;
   logic                      r_ovf;
   logic [DROP_CNT_W-1:0]     r_drop_cnt;

   logic                      w_full;
   logic                      w_empty;
   logic                      w_wr;
   logic                      w_rd;
   logic                      w_discard;
   logic                      w_patch;
   logic [C_MEM_W-1:0]        w_rdata;

   assign w_full     = (r_count == C_CNT_FULL);
   assign w_empty    = (r_count == '0);
   assign w_wr       = S_AXIS_TVALID & ~w_full & (r_state == ST_NORMAL);
   assign w_rd       = ~w_empty & M_AXIS_TREADY;
   assign w_last_ptr = r_wr_ptr - C_PTR_ONE;

   // Overflow in NORMAL closes the stored packet; DROP swallows the rest.
   always_comb begin
      w_state_nxt = r_state;
      w_discard   = 1'b0;
      w_patch     = 1'b0;
      case (r_state)
         ST_NORMAL: begin
            if (S_AXIS_TVALID && w_full) begin
               w_discard = 1'b1;
               w_patch   = 1'b1;
               if (!S_AXIS_TLAST) begin
                  w_state_nxt = ST_DROP;
               end
            end
         end
         ST_DROP: begin
            if (S_AXIS_TVALID) begin
               w_discard = 1'b1;
               if (S_AXIS_TLAST) begin
                  w_state_nxt = ST_NORMAL;
               end
            end
         end
         default: w_state_nxt = ST_NORMAL;
      endcase
   end

   always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
      if (AXIS_ARESET) begin
         r_state <= ST_NORMAL;
      end else if (clr) begin
         r_state <= ST_NORMAL;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
      if (AXIS_ARESET) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (clr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
         end
         if (w_rd) begin
            r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
         end
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + C_CNT_ONE;
            2'b01:   r_count <= r_count - C_CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // Patch target is never the head: a patch only happens when full (count >= 2).
   always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
      if (AXIS_ARESET) begin
         r_tlast <= '0;
      end else if (clr) begin
         r_tlast <= '0;
      end else if (w_wr) begin
         r_tlast[r_wr_ptr] <= S_AXIS_TLAST;
      end else if (w_patch) begin
         r_tlast[w_last_ptr] <= 1'b1;
      end
   end

   always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
      if (AXIS_ARESET) begin
         r_ovf      <= 1'b0;
         r_drop_cnt <= '0;
      end else if (clr) begin
         r_ovf      <= 1'b0;
         r_drop_cnt <= '0;
      end else begin
         if (w_patch) begin
            r_ovf <= 1'b1;
         end
         if (w_discard && (r_drop_cnt != C_DROP_MAX)) begin
            r_drop_cnt <= r_drop_cnt + C_DROP_ONE;
         end
      end
   end

   adi2axis_fifo_ram #(
      .WIDTH  (C_MEM_W),
      .ADDR_W (C_DEPTH_LOG2)
   ) u_ram (
      .clk     (AXIS_ACLK),
      .i_we    (w_wr & ~clr),
      .i_waddr (r_wr_ptr),
      .i_wdata ({S_AXIS_TDATA, S_AXIS_TSTRB}),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_rdata)
   );

   assign S_AXIS_TREADY = ~w_full;
   assign M_AXIS_TVALID = ~w_empty;
   assign M_AXIS_TDATA  = w_rdata[C_MEM_W-1:C_AXIS_TDATA_NUM_BYTES];
   assign M_AXIS_TSTRB  = w_rdata[C_AXIS_TDATA_NUM_BYTES-1:0];
   assign M_AXIS_TLAST  = r_tlast[r_rd_ptr];
   assign level         = r_count;
   assign ovf           = r_ovf;
   assign drop_cnt      = r_drop_cnt;

endmodule : adi2axis_fifo
`default_nettype wire

// File: doc/adi2axis_fifo.md
# adi2axis_fifo

Elastic AXI-Stream buffer placed directly downstream of the ADC-to-AXIS converter, ahead of the DMA. The converter cannot stall the ADC, so this block absorbs DMA backpressure. On overflow it discards beats in whole-packet units and closes the truncated packet, so DMA framing stays intact. Overflow and drop status is exported for the control register file.

## Interface
- C_AXIS_TDATA_NUM_BYTES, 8, bytes per beat; TDATA width is 8×this.
- C_DEPTH_LOG2, 9, FIFO depth DEPTH = 2^C_DEPTH_LOG2 (minimum 2).

Ports:
- AXIS_ACLK  in  1  single clock for all logic.
- AXIS_ARESET  in  1  asynchronous, active-high reset.
- S_AXIS_TVALID  in  1  upstream beat valid; may assert regardless of TREADY.
- S_AXIS_TDATA  in  8×C_AXIS_TDATA_NUM_BYTES  upstream data.
- S_AXIS_TSTRB  in  C_AXIS_TDATA_NUM_BYTES  upstream strobes, stored with data.
- S_AXIS_TLAST  in  1  upstream end of packet.
- S_AXIS_TREADY  out  1  equals ~full.
- M_AXIS_TVALID  out  1  equals ~empty.
- M_AXIS_TDATA  out  8×C_AXIS_TDATA_NUM_BYTES  head-of-FIFO data.
- M_AXIS_TSTRB  out  C_AXIS_TDATA_NUM_BYTES  head-of-FIFO strobes.
- M_AXIS_TLAST  out  1  head-of-FIFO last flag.
- M_AXIS_TREADY  in  1  downstream ready.
- clr  in  1  synchronous flush, driven from the ctrl reset value.
- level  out  C_DEPTH_LOG2+1  current occupancy, 0..DEPTH.
- ovf  out  1  sticky overflow flag.
- drop_cnt  out  16  count of discarded beats, saturates at 0xFFFF.

## Operation
- wr = S_AXIS_TVALID & ~full & state==NORMAL.
- rd = M_AXIS_TVALID & M_AXIS_TREADY.
- The storage array holds {TDATA, TSTRB}. TLAST bits live in a separate flop array so that individual entries can be patched.
- Occupancy update: count += wr − rd. full = (count==DEPTH). empty = (count==0).
- Pointers are C_DEPTH_LOG2 bits wide and wrap naturally modulo DEPTH.
- State machine, two states:
  - NORMAL:
    - If S_AXIS_TVALID & full, the beat is discarded. Set ovf, increment drop_cnt, and set tlast[wr_ptr−1] = 1.
    - That entry is always unread, because full implies count ≥ 2.
    - If the discarded beat has TLAST=0, go to DROP. Otherwise stay in NORMAL.
  - DROP:
    - Every S_AXIS_TVALID beat is discarded and increments drop_cnt. No writes occur, even when space is available.
    - A discarded beat with TLAST=1 returns the state to NORMAL. The next beat is written normally.
- If the patched entry already had TLAST=1 (overflow on the first beat of a packet), the patch has no effect and the whole packet is lost.
- Simultaneous rd while full: the freed slot becomes visible on the next cycle. An S_AXIS beat arriving in the same cycle is still discarded.
- clr has the same effect as reset but is synchronous: pointers, count, state, ovf and drop_cnt are all cleared. clr takes priority over wr, rd and patching in its cycle.
- Reset values: S_AXIS_TREADY=1, M_AXIS_TVALID=0, M_AXIS_TLAST=0, level=0, ovf=0, drop_cnt=0, state NORMAL.
- M_AXIS_TDATA and M_AXIS_TSTRB are don't-care while M_AXIS_TVALID=0.

## Timing
- First-word fall-through. A beat written at edge N is presented with M_AXIS_TVALID=1 after edge N, giving one-cycle write-to-output latency.
- Memory read is combinational from rd_ptr (distributed RAM).
- M_AXIS outputs are held stable while TVALID=1 and TREADY=0.
- S_AXIS_TREADY, M_AXIS_TVALID and level are derived from registered count only, with no combinational path from the TVALID or TREADY inputs.
- A TLAST patch applies at edge N. If the patched entry is at the head, M_AXIS_TLAST reflects the patch after edge N.
- The ovf and drop_cnt updates are visible one cycle after the offending beat.
- Full throughput: one write and one read per cycle is sustained with no bubbles.

## Structure
- The shared package holds:
  - state encoding (ST_NORMAL, ST_DROP);
  - the DROP_CNT_W=16 constant;
  - a function computing TDATA width from byte count, which is reused by the converter.
- Natural sub-module: adi2axis_fifo_ram, a simple dual-port array with a synchronous write port and an asynchronous read port holding {TDATA, TSTRB}.
- The TLAST array, pointers and state machine stay in the top-level module.

## Test plan
- Pass-through: 4-beat packet 0x11..0x44 with TLAST on 0x44 and M_AXIS_TREADY=1. Output is 0x11..0x44 with one-cycle latency and TLAST only on 0x44; level peaks at 1.
- Fill to full: DEPTH=4, hold M_AXIS_TREADY=0, write 4 beats. Then level=4 and S_AXIS_TREADY=0; ovf=0 and drop_cnt=0.
- Mid-packet overflow:
  - Setup: DEPTH=4, M_AXIS_TREADY=0, a 6-beat packet A0..A5.
  - Expected after the packet: A0..A3 are stored, A3 is patched to TLAST=1, A4 and A5 are dropped, drop_cnt=2 and ovf=1.
  - Follow-up: release M_AXIS_TREADY and send packet B. The output is A0..A3 (last on A3), then B intact.
- Drop persists with space: after an overflow in DROP, drain the FIFO while further non-last beats arrive. Those beats are still discarded until the TLAST beat; the next packet is accepted.
- Simultaneous read and write: at steady state with count=2 and continuous traffic for 100 beats, level stays at 2 and there are no drops.
- clr and reset mid-operation:
  - clr with level=3 and ovf=1 gives level=0, ovf=0, drop_cnt=0 and M_AXIS_TVALID=0 on the next cycle.
  - Asserting AXIS_ARESET mid-packet clears all outputs immediately, without waiting for a clock edge.
